// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding and the double-dabble digit adjust constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_INC    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit correction: a digit of 5 or more gets 3
// added (wrapping at 16) so that the following left shift carries correctly.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= ADJ_THRESH) begin
      adjusted = digit + ADJ_INC;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (double dabble), one bit per clock, MSB first.
// The published BCD/OVF registers change only at the end of a conversion.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  OVF
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 32 || DIGITS < 1 || DIGITS > 10) begin : g_bad_params
    $error("bin2bcd_seq: WIDTH must be 1..32 and DIGITS must be 1..10");
  end

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [WIDTH-1:0]  shift_reg, shift_next;
  logic [BW-1:0]     dig_reg, dig_next;
  logic              ovf_work_reg, ovf_work_next;
  logic [BW-1:0]     bcd_reg, bcd_next;
  logic              ovf_reg, ovf_next;

  logic [BW-1:0]       adj_dig;
  logic [BW+WIDTH-1:0] joined;
  logic [BW+WIDTH-1:0] shifted;
  logic                carry;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (dig_reg[4*gi +: 4]),
      .adjusted (adj_dig[4*gi +: 4])
    );
  end

  // Digits and operand shift together as one vector; the bit leaving the
  // top digit is the overflow indication.
  assign joined  = {adj_dig, shift_reg};
  assign shifted = {joined[BW+WIDTH-2:0], 1'b0};
  assign carry   = joined[BW+WIDTH-1];

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    dig_next      = dig_reg;
    ovf_work_next = ovf_work_reg;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;

    case (state_reg)
      IDLE, FIN: begin
        state_next = IDLE;
        if (START) begin
          state_next    = SHIFT;
          cnt_next      = '0;
          shift_next    = BIN;
          dig_next      = '0;
          ovf_work_next = 1'b0;
        end
      end
      SHIFT: begin
        dig_next      = shifted[BW+WIDTH-1:WIDTH];
        shift_next    = shifted[WIDTH-1:0];
        ovf_work_next = ovf_work_reg | carry;
        cnt_next      = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = FIN;
          bcd_next   = shifted[BW+WIDTH-1:WIDTH];
          ovf_next   = ovf_work_reg | carry;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      dig_reg      <= '0;
      ovf_work_reg <= 1'b0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      dig_reg      <= dig_next;
      ovf_work_reg <= ovf_work_next;
      bcd_reg      <= bcd_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign BUSY = (state_reg == SHIFT);
  assign DONE = (state_reg == FIN);
  assign BCD  = bcd_reg;
  assign OVF  = ovf_reg;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: width of the binary input, legal range 1 to 32.
REQ-002 The block SHALL take parameter DIGITS, default 3: number of BCD digits produced, legal range 1 to 10.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 START  input  1  conversion request, sampled on the CLK rising edge.
REQ-006 BIN  input  WIDTH  unsigned binary operand, sampled in the cycle START is accepted.
REQ-007 BUSY  output  1  high while a conversion is in progress.
REQ-008 DONE  output  1  single-cycle pulse marking that a result is complete.
REQ-009 BCD  output  4*DIGITS  packed result; digit 0 (ones) in bits [3:0], digit k in bits [4k+3:4k].
REQ-010 OVF  output  1  high when the result did not fit in DIGITS digits; valid together with BCD.

Function
REQ-011 The conversion SHALL be iterative shift-and-add-3 (double dabble), one bit per cycle, MSB of BIN first.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and FIN.
REQ-013 Transitions SHALL be: IDLE->SHIFT on START; SHIFT->FIN after WIDTH shift cycles; FIN->SHIFT on START; FIN->IDLE otherwise.
REQ-014 START SHALL be accepted only in IDLE or FIN; START while BUSY is high SHALL be ignored, with no effect on state, result or outputs.
REQ-015 On acceptance, BIN SHALL be captured into an internal shift register, the working digits SHALL be cleared to 0, and the overflow flag SHALL be cleared.
REQ-016 Each SHIFT cycle, every working digit >= 5 SHALL first be incremented by 3 (mod 16), then digits and shift register SHALL shift left one bit as a single 4*DIGITS+WIDTH-bit vector.
REQ-017 A 1 shifted out of the top digit during any SHIFT cycle SHALL set the internal overflow flag, which stays set for the rest of that conversion.
REQ-018 Latency: with START accepted at edge 0, BUSY SHALL be high after edges 1..WIDTH; DONE, BCD and OVF SHALL update after edge WIDTH+1 (FIN).
REQ-019 DONE SHALL be high for exactly one cycle per conversion; BUSY SHALL be low in that cycle.
REQ-020 BCD and OVF SHALL hold the last completed result until the next DONE or reset; intermediate working values SHALL never appear on BCD.
REQ-021 START in the FIN cycle SHALL begin a new conversion back-to-back, giving one result every WIDTH+1 cycles.
REQ-022 When OVF is 1, BCD SHALL carry the low DIGITS digits of the true decimal value (truncated, not saturated).
REQ-023 BIN = 0 SHALL still take the full WIDTH+1 cycles and yield BCD = 0, OVF = 0.

Reset
REQ-024 While RST_N is low at a rising edge, the FSM SHALL enter IDLE, and BUSY, DONE, OVF and all BCD bits SHALL become 0.
REQ-025 A reset in the middle of a conversion SHALL abort it, and no DONE SHALL be produced for that conversion.
REQ-026 START sampled in the same edge as an active reset SHALL be ignored.

Structure
REQ-027 The FSM state encoding (IDLE, SHIFT, FIN) and the per-digit adjust threshold (5) and increment (3) SHALL be defined in a shared package, bcd_pkg.
REQ-028 The per-digit conditional add-3 SHALL be a combinational sub-module, bcd_digit_adj (4-bit in, 4-bit out), instantiated DIGITS times with a generate loop.
REQ-029 The state counter SHALL be sized clog2(WIDTH+1) bits.
REQ-030 Illegal WIDTH or DIGITS values SHALL be flagged by an elaboration-time check.

Verification
REQ-031 WIDTH=8, DIGITS=3, BIN=255, START for 1 cycle: DONE after 9 cycles, BCD=0x255, OVF=0.
REQ-032 WIDTH=8, DIGITS=3, BIN=0, then BIN=99 started in the FIN cycle: BCD=0x000, then 0x099 exactly 9 cycles later.
REQ-033 WIDTH=16, DIGITS=5, BIN=65535: DONE after 17 cycles, BCD=0x65535, OVF=0.
REQ-034 WIDTH=8, DIGITS=2, BIN=150: BCD=0x50, OVF=1.
REQ-035 WIDTH=8, DIGITS=3, START with BIN=200, then START with BIN=7 at cycle 3: exactly one DONE, at cycle 9, with BCD=0x200.
REQ-036 RST_N low at cycle 4 of a conversion: no DONE, BUSY=0 and BCD=0 after that edge; the next START converts normally.
